// File: rtl/idct4_butterfly_pipe_if.sv
// Stream interface for the 4-point IDCT butterfly: input vector side and output vector side.
interface idct4_butterfly_pipe_if #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 16
);
  logic                    in_valid;
  logic                    in_ready;
  logic                    in_last;
  logic signed [IN_W-1:0]  x0, x1, x2, x3;
  logic                    out_valid;
  logic                    out_ready;
  logic                    out_last;
  logic signed [OUT_W-1:0] y0, y1, y2, y3;
  logic                    sat_flag;

  modport master (
    output in_valid, in_last, x0, x1, x2, x3, out_ready,
    input  in_ready, out_valid, out_last, y0, y1, y2, y3, sat_flag
  );

  modport slave (
    input  in_valid, in_last, x0, x1, x2, x3, out_ready,
    output in_ready, out_valid, out_last, y0, y1, y2, y3, sat_flag
  );
endinterface

// File: rtl/idct4_butterfly_pipe.sv
// HEVC 4-point inverse DCT (64/83/36), even/odd butterfly, two-stage pipeline with backpressure.
// Optional output clipping and sat_flag enabled by defining IDCT4_SAT_EN; default wraps to OUT_W.
module idct4_butterfly_pipe #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 16,
  parameter int SHIFT = 7
) (
  input logic             clk,
  input logic             reset,
  idct4_butterfly_pipe_if.slave io
);

  localparam int ACC_W = IN_W + 10;
  typedef logic signed [ACC_W-1:0] acc_t;
  typedef logic signed [OUT_W-1:0] out_t;

  localparam acc_t C64 = acc_t'(64);
  localparam acc_t C83 = acc_t'(83);
  localparam acc_t C36 = acc_t'(36);
  localparam acc_t RND = acc_t'(1) <<< (SHIFT - 1);

  function automatic acc_t round_shift(input acc_t raw);
    return (raw + RND) >>> SHIFT;
  endfunction

`ifdef IDCT4_SAT_EN
  localparam acc_t MAXV = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam acc_t MINV = {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  function automatic logic is_clip(input acc_t r);
    return (r > MAXV) || (r < MINV);
  endfunction

  function automatic out_t narrow(input acc_t r);
    if (r > MAXV)      return MAXV[OUT_W-1:0];
    else if (r < MINV) return MINV[OUT_W-1:0];
    else               return r[OUT_W-1:0];
  endfunction
`else
  function automatic out_t narrow(input acc_t r);
    return r[OUT_W-1:0];
  endfunction
`endif

  logic en;
  logic vld_p1_q, last_p1_q;
  acc_t e0_p1_q, e1_p1_q, o0_p1_q, o1_p1_q;
  acc_t e0_p1_d, e1_p1_d, o0_p1_d, o1_p1_d;
  acc_t x0_s, x1_s, x2_s, x3_s;
  logic vld_p2_q, last_p2_q;
  acc_t r_p2[4];
  out_t y_p2_d[4];
  out_t y_p2_q[4];

  // Whole pipeline advances together; a stalled output freezes every stage.
  assign en          = !vld_p2_q || io.out_ready;
  assign io.in_ready = en;

  // Stage 1: even/odd butterfly terms
  assign x0_s = acc_t'(io.x0);
  assign x1_s = acc_t'(io.x1);
  assign x2_s = acc_t'(io.x2);
  assign x3_s = acc_t'(io.x3);

  always_comb begin
    e0_p1_d = C64 * (x0_s + x2_s);
    e1_p1_d = C64 * (x0_s - x2_s);
    o0_p1_d = C83 * x1_s + C36 * x3_s;
    o1_p1_d = C36 * x1_s - C83 * x3_s;
  end

  always_ff @(posedge clk) begin
    if (reset)   vld_p1_q <= 1'b0;
    else if (en) vld_p1_q <= io.in_valid;
  end

  always_ff @(posedge clk) begin
    if (en) begin
      e0_p1_q   <= e0_p1_d;
      e1_p1_q   <= e1_p1_d;
      o0_p1_q   <= o0_p1_d;
      o1_p1_q   <= o1_p1_d;
      last_p1_q <= io.in_last;
    end
  end

  // Stage 2: recombine, round, narrow
  always_comb begin
    r_p2[0] = round_shift(e0_p1_q + o0_p1_q);
    r_p2[1] = round_shift(e1_p1_q + o1_p1_q);
    r_p2[2] = round_shift(e1_p1_q - o1_p1_q);
    r_p2[3] = round_shift(e0_p1_q - o0_p1_q);
    for (int i = 0; i < 4; i++) y_p2_d[i] = narrow(r_p2[i]);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      vld_p2_q  <= 1'b0;
      last_p2_q <= 1'b0;
      for (int i = 0; i < 4; i++) y_p2_q[i] <= '0;
    end else if (en) begin
      vld_p2_q  <= vld_p1_q;
      last_p2_q <= last_p1_q;
      for (int i = 0; i < 4; i++) y_p2_q[i] <= y_p2_d[i];
    end
  end

`ifdef IDCT4_SAT_EN
  logic sat_p2_q, sat_p2_d;
  assign sat_p2_d = is_clip(r_p2[0]) | is_clip(r_p2[1]) | is_clip(r_p2[2]) | is_clip(r_p2[3]);

  always_ff @(posedge clk) begin
    if (reset)   sat_p2_q <= 1'b0;
    else if (en) sat_p2_q <= sat_p2_d;
  end

  assign io.sat_flag = sat_p2_q;
`else
  assign io.sat_flag = 1'b0;
`endif

  assign io.out_valid = vld_p2_q;
  assign io.out_last  = last_p2_q;
  assign io.y0        = y_p2_q[0];
  assign io.y1        = y_p2_q[1];
  assign io.y2        = y_p2_q[2];
  assign io.y3        = y_p2_q[3];

endmodule

// File: tb/tb_idct4_butterfly_pipe.sv
// Directed bench for idct4_butterfly_pipe: single vectors, saturation, stall, last tag, mid-flight reset.
module tb_idct4_butterfly_pipe;
  localparam int IN_W  = 16;
  localparam int OUT_W = 16;
  localparam int SHIFT = 7;

  logic clk = 1'b0;
  logic reset;
  int   n_chk = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  idct4_butterfly_pipe_if #(.IN_W(IN_W), .OUT_W(OUT_W)) io ();

  idct4_butterfly_pipe #(.IN_W(IN_W), .OUT_W(OUT_W), .SHIFT(SHIFT)) dut (
    .clk  (clk),
    .reset(reset),
    .io   (io)
  );

  task automatic check_eq(input string tag, input logic signed [31:0] got,
                          input logic signed [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Called at posedge+1; offers one vector on an idle pipe and checks 2-cycle latency.
  task automatic send_one(input int a0, input int a1, input int a2, input int a3,
                          input int e0, input int e1, input int e2, input int e3,
                          input int esat, input string tag);
    io.in_valid  = 1'b1;
    io.in_last   = 1'b0;
    io.out_ready = 1'b1;
    io.x0 = IN_W'(a0); io.x1 = IN_W'(a1); io.x2 = IN_W'(a2); io.x3 = IN_W'(a3);
    #1;
    check_eq({tag, "_in_ready"}, io.in_ready, 1);
    @(posedge clk); #1;
    io.in_valid = 1'b0;
    check_eq({tag, "_lat1_valid"}, io.out_valid, 0);
    @(posedge clk); #1;
    check_eq({tag, "_lat2_valid"}, io.out_valid, 1);
    check_eq({tag, "_y0"}, io.y0, e0);
    check_eq({tag, "_y1"}, io.y1, e1);
    check_eq({tag, "_y2"}, io.y2, e2);
    check_eq({tag, "_y3"}, io.y3, e3);
    check_eq({tag, "_sat"}, io.sat_flag, esat);
    @(posedge clk); #1;
    check_eq({tag, "_drained"}, io.out_valid, 0);
  endtask

  // Vector k carries x=(128k,0,128,0) -> y=(64(k+1), 64(k-1), 64(k-1), 64(k+1)).
  // mode 0: out_ready=1; mode 1: 4-cycle stall from first out_valid; mode 2: random out_ready.
  task automatic run_stream(input int n, input int mode, input int last_a, input int last_b,
                            input string tag);
    int sent = 0, got = 0, cyc = 0, stall_cnt = 0;
    logic prev_stall = 1'b0;
    logic signed [OUT_W-1:0] hold_y0 = '0;
    logic hold_last = 1'b0;
    int k;
    while (got < n && cyc < 300) begin
      io.in_valid = (sent < n);
      io.x0 = IN_W'(128 * (sent + 1)); io.x1 = '0; io.x2 = IN_W'(128); io.x3 = '0;
      io.in_last = ((sent + 1) == last_a) || ((sent + 1) == last_b);
      if (mode == 1 && stall_cnt < 4 && (io.out_valid || stall_cnt > 0)) begin
        io.out_ready = 1'b0;
        stall_cnt++;
      end else if (mode == 2) begin
        io.out_ready = 1'($urandom_range(0, 1));
      end else begin
        io.out_ready = 1'b1;
      end
      #1;
      if (prev_stall) begin
        check_eq({tag, "_hold_y0"}, io.y0, hold_y0);
        check_eq({tag, "_hold_last"}, io.out_last, hold_last);
      end
      if (io.out_valid && !io.out_ready) begin
        check_eq({tag, "_stall_in_ready"}, io.in_ready, 0);
        prev_stall = 1'b1;
        hold_y0    = io.y0;
        hold_last  = io.out_last;
      end else begin
        prev_stall = 1'b0;
      end
      if (io.out_valid && io.out_ready) begin
        k = got + 1;
        check_eq({tag, "_y0"}, io.y0, 64 * (k + 1));
        check_eq({tag, "_y1"}, io.y1, 64 * (k - 1));
        check_eq({tag, "_y2"}, io.y2, 64 * (k - 1));
        check_eq({tag, "_y3"}, io.y3, 64 * (k + 1));
        check_eq({tag, "_last"}, io.out_last, (k == last_a) || (k == last_b));
        got++;
      end
      if (io.in_valid && io.in_ready) sent++;
      @(posedge clk); #1;
      cyc++;
    end
    io.in_valid  = 1'b0;
    io.in_last   = 1'b0;
    io.out_ready = 1'b1;
    check_eq({tag, "_count"}, got, n);
    check_eq({tag, "_no_extra"}, io.out_valid, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    io.in_valid = 1'b0; io.in_last = 1'b0; io.out_ready = 1'b1;
    io.x0 = '0; io.x1 = '0; io.x2 = '0; io.x3 = '0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_out_valid", io.out_valid, 0);
    check_eq("rst_y0", io.y0, 0);
    check_eq("rst_y3", io.y3, 0);
    check_eq("rst_out_last", io.out_last, 0);
    check_eq("rst_sat", io.sat_flag, 0);
    check_eq("rst_in_ready", io.in_ready, 1);
    reset = 1'b0;
    @(posedge clk); #1;

    send_one(1, 0, 0, 0, 1, 1, 1, 1, 0, "dc1");
    send_one(0, 1, 0, 0, 1, 0, 0, -1, 0, "odd1");
    send_one(0, 0, 0, 1, 0, -1, 1, 0, 0, "odd3");
`ifdef IDCT4_SAT_EN
    send_one(32767, 32767, 32767, 32767, 32767, -12032, 12032, 2304, 1, "maxin");
`else
    send_one(32767, 32767, 32767, 32767, -2306, -12032, 12032, 2304, 0, "maxin");
`endif

    run_stream(5, 1, 0, 0, "stall");
    run_stream(10, 2, 4, 8, "lasttag");
    run_stream(4, 0, 4, 0, "full");

    // Two vectors in flight, then a one-cycle reset with a third vector offered.
    io.out_ready = 1'b0;
    io.in_valid  = 1'b1;
    io.x0 = IN_W'(128); io.x1 = '0; io.x2 = IN_W'(128); io.x3 = '0; io.in_last = 1'b1;
    @(posedge clk); #1;
    io.x0 = IN_W'(256);
    @(posedge clk); #1;
    check_eq("inflight_valid", io.out_valid, 1);
    reset = 1'b1;
    io.x0 = IN_W'(384);
    @(posedge clk); #1;
    reset = 1'b0;
    io.in_valid = 1'b0;
    io.in_last  = 1'b0;
    check_eq("mid_rst_out_valid", io.out_valid, 0);
    check_eq("mid_rst_y0", io.y0, 0);
    check_eq("mid_rst_last", io.out_last, 0);
    check_eq("mid_rst_in_ready", io.in_ready, 1);
    io.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check_eq("mid_rst_flushed", io.out_valid, 0);
    end
    send_one(640, 0, 128, 0, 384, 256, 256, 384, 0, "post_rst");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
